// File: rtl/barrier_pkt_arbiter_if.sv
// barrier_pkt_arbiter_if
//   Bundles the two ingress word streams, their ready flags and the merged
//   egress stream of barrier_pkt_arbiter.
//   Signals:
//     in0_data/in0_ctrl/in0_wr, in0_rdy : CPU-side ingress word and ready
//     in1_data/in1_ctrl/in1_wr, in1_rdy : network-side ingress word and ready
//     out_data/out_ctrl/out_wr, out_rdy : merged egress word and downstream ready
//   Modports:
//     master : traffic source / sink side (drives ingress, consumes egress)
//     slave  : the arbiter itself
interface barrier_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in0_data;
    logic [CTRL_WIDTH-1:0] in0_ctrl;
    logic                  in0_wr;
    logic                  in0_rdy;
    logic [DATA_WIDTH-1:0] in1_data;
    logic [CTRL_WIDTH-1:0] in1_ctrl;
    logic                  in1_wr;
    logic                  in1_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        output in0_data, in0_ctrl, in0_wr,
        input  in0_rdy,
        output in1_data, in1_ctrl, in1_wr,
        input  in1_rdy,
        input  out_data, out_ctrl, out_wr,
        output out_rdy
    );

    modport slave (
        input  in0_data, in0_ctrl, in0_wr,
        output in0_rdy,
        input  in1_data, in1_ctrl, in1_wr,
        output in1_rdy,
        output out_data, out_ctrl, out_wr,
        input  out_rdy
    );
endinterface

// File: rtl/barrier_pkt_arbiter.sv
// barrier_pkt_arbiter
//   Two-input packet-granular round-robin arbiter. Each input is buffered in
//   its own 2**FIFO_DEPTH_BITS-word FIFO; a grant is held from the first read
//   word until the end-of-packet word (ctrl!=0 after at least one ctrl==0
//   word), so packets never interleave on the output.
//   Ports:
//     clk      : single clock
//     reset    : asynchronous, active-high
//     bus      : barrier_pkt_arbiter_if.slave (in0/in1 ingress, out egress)
//     pkt_cnt0 : completed packets from port 0, saturating (BARRIER_PKT_CNT_EN only)
//     pkt_cnt1 : completed packets from port 1, saturating (BARRIER_PKT_CNT_EN only)
//   Build option: define BARRIER_PKT_CNT_EN to add the packet counters.
module barrier_pkt_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    barrier_pkt_arbiter_if.slave bus
`ifdef BARRIER_PKT_CNT_EN
    ,
    output logic [15:0]          pkt_cnt0,
    output logic [15:0]          pkt_cnt1
`endif
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

    typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_BITS:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    logic [WORD_W-1:0]     mem [2][DEPTH];
    ptr_t                  wr_ptr [2];
    ptr_t                  rd_ptr [2];
    cnt_t                  count  [2];
    logic [WORD_W-1:0]     wr_word [2];
    logic [1:0]            wr_req;
    logic [1:0]            wr_en;
    logic [1:0]            rd_en;
    logic [1:0]            empty;
    logic [1:0]            full;
    logic [1:0]            nearly_full;
    logic [WORD_W-1:0]     rd_word;
    logic [CTRL_WIDTH-1:0] rd_ctrl;
    logic                  pkt_done;

    state_t                state;
    logic                  last_served;
    logic                  in_payload;

    assign wr_word[0] = {bus.in0_ctrl, bus.in0_data};
    assign wr_word[1] = {bus.in1_ctrl, bus.in1_data};
    assign wr_req     = {bus.in1_wr, bus.in0_wr};

    assign bus.in0_rdy = ~nearly_full[0];
    assign bus.in1_rdy = ~nearly_full[1];

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            empty[p]       = (count[p] == '0);
            full[p]        = (count[p] == cnt_t'(DEPTH));
            nearly_full[p] = (count[p] >= cnt_t'(DEPTH - 1));
        end
        // A write into a full FIFO is dropped even if a read frees a slot
        // in the same cycle.
        wr_en = wr_req & ~full;
        rd_en = '0;
        case (state)
            SEND0:   rd_en[0] = bus.out_rdy & ~empty[0];
            SEND1:   rd_en[1] = bus.out_rdy & ~empty[1];
            default: rd_en = '0;
        endcase
        rd_word  = (state == SEND1) ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
        rd_ctrl  = rd_word[WORD_W-1:DATA_WIDTH];
        // End of packet: a control word read after payload in this grant.
        pkt_done = (|rd_en) && (rd_ctrl != '0) && in_payload;
    end

    // Storage is not reset; emptiness is carried entirely by the counters.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                mem[p][wr_ptr[p]] <= wr_word[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                if (rd_en[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                end
                case ({wr_en[p], rd_en[p]})
                    2'b10:   count[p] <= count[p] + 1'b1;
                    2'b01:   count[p] <= count[p] - 1'b1;
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_served  <= 1'b1;
            in_payload   <= 1'b0;
            bus.out_wr   <= 1'b0;
            bus.out_data <= '0;
            bus.out_ctrl <= '0;
`ifdef BARRIER_PKT_CNT_EN
            pkt_cnt0     <= '0;
            pkt_cnt1     <= '0;
`endif
        end else begin
            bus.out_wr <= |rd_en;
            if (|rd_en) begin
                bus.out_data <= rd_word[DATA_WIDTH-1:0];
                bus.out_ctrl <= rd_ctrl;
            end

            case (state)
                IDLE: begin
                    in_payload <= 1'b0;
                    if (!empty[0] && !empty[1]) begin
                        state <= last_served ? SEND0 : SEND1;
                    end else if (!empty[0]) begin
                        state <= SEND0;
                    end else if (!empty[1]) begin
                        state <= SEND1;
                    end
                end
                SEND0, SEND1: begin
                    if (pkt_done) begin
                        state       <= IDLE;
                        last_served <= (state == SEND1);
                        in_payload  <= 1'b0;
                    end else if ((|rd_en) && (rd_ctrl == '0)) begin
                        in_payload  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef BARRIER_PKT_CNT_EN
            if (pkt_done && (state == SEND0) && (pkt_cnt0 != '1)) begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
            if (pkt_done && (state == SEND1) && (pkt_cnt1 != '1)) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/barrier_pkt_arbiter.md
BARRIER_PKT_ARBITER -- requirements
Module: barrier_pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control word width.
REQ-003 SHALL have parameter FIFO_DEPTH_BITS, default 2, log2 of the per-input FIFO depth (4 words).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports in0_data/in0_ctrl/in0_wr, inputs, DATA_WIDTH/CTRL_WIDTH/1, CPU-side ingress word.
REQ-007 SHALL have port in0_rdy, output, 1, CPU-side ready.
REQ-008 SHALL have ports in1_data/in1_ctrl/in1_wr, inputs, DATA_WIDTH/CTRL_WIDTH/1, network-side ingress word.
REQ-009 SHALL have port in1_rdy, output, 1, network-side ready.
REQ-010 SHALL have ports out_data/out_ctrl/out_wr, outputs, DATA_WIDTH/CTRL_WIDTH/1, merged egress word toward the output port lookup stage.
REQ-011 SHALL have port out_rdy, input, 1, downstream ready.

Function
REQ-012 SHALL buffer each input in its own FIFO of 2**FIFO_DEPTH_BITS words, writing on inN_wr.
REQ-013 SHALL drive inN_rdy = !nearly_full, where nearly_full is asserted at depth-1 occupancy.
REQ-014 SHALL silently discard a word written while its FIFO is full, leaving the FIFO contents unchanged.
REQ-015 SHALL arbitrate at packet granularity using the states IDLE, SEND0 and SEND1.
REQ-016 In IDLE, SHALL grant the port whose FIFO is non-empty; when both are non-empty, SHALL grant the port not served last (round-robin).
REQ-017 SHALL move from IDLE to the granted SENDn state in one cycle, with no FIFO read in the IDLE cycle.
REQ-018 In SENDn, SHALL read FIFO n when out_rdy=1 and FIFO n is non-empty; no other FIFO is read.
REQ-019 SHALL recognise a packet as complete on a read word with ctrl!=0 that follows at least one read word with ctrl==0 in the same grant.
REQ-020 SHALL track the in-payload flag per grant, cleared on entry to SENDn.
REQ-021 On reading the end-of-packet word, SHALL return to IDLE, record n as last served, and clear the in-payload flag.
REQ-022 SHALL present out_data/out_ctrl from the read FIFO and assert out_wr in the cycle after the read.
REQ-023 SHALL give 1-cycle read-to-out_wr latency and 3-cycle minimum latency from an empty-FIFO write to out_wr.
REQ-024 SHALL hold the grant through an empty FIFO mid-packet (no interleaving) and SHALL stall without reading while out_rdy=0.
REQ-025 SHALL never interleave words from two packets on the output.
REQ-026 SHALL keep writes and a read to the same FIFO in one cycle both effective, leaving the occupancy unchanged.

Reset
REQ-027 On reset assertion, SHALL immediately clear out_wr, set state=IDLE, set last served=1 (port 0 wins the first tie), clear the in-payload flag and empty both FIFOs.
REQ-028 On reset assertion, SHALL drive in0_rdy=in1_rdy=1 on the first clock after reset is released.
REQ-029 On reset assertion mid-packet, SHALL discard the partial packet, with no resumption after reset.

Configuration
REQ-030 When macro BARRIER_PKT_CNT_EN is defined, SHALL add outputs pkt_cnt0 and pkt_cnt1, 16 bits each, reset to 0.
REQ-031 With BARRIER_PKT_CNT_EN defined, SHALL increment pkt_cntN on each completed packet from port N and SHALL saturate pkt_cntN at 0xFFFF.
REQ-032 Without BARRIER_PKT_CNT_EN, the ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-033 Bench SHALL cover: only in0 sends a 3-word packet (ctrl FF,00,01), out_rdy=1 -> same 3 words out, out_wr 3 cycles, order kept.
REQ-034 Bench SHALL cover: both inputs load packets in the same cycle after reset -> port 0 packet fully out, then port 1 packet.
REQ-035 Bench SHALL cover: port 1 starves mid-packet for 5 cycles while port 0 is full -> no port 0 word is emitted until port 1 EOP.
REQ-036 Bench SHALL cover: out_rdy=0 for 10 cycles with both FIFOs holding 3 words -> out_wr=0 throughout, in0_rdy=in1_rdy=0, no loss after release.
REQ-037 Bench SHALL cover: reset pulsed after 2 of 4 words -> out_wr=0 immediately, FIFOs empty, next packet on port 0 is output intact.
REQ-038 Bench SHALL cover, with BARRIER_PKT_CNT_EN defined: 3 packets on port 1 -> pkt_cnt1=3, pkt_cnt0=0; preloading 0xFFFF then 1 more packet -> stays 0xFFFF.
